handshake_processor_core: RTL and testbench

Parametrised successor of the 12-bit accumulator processor core: same accumulator/register-file/PC programming model, generalised in data width, register-file depth and start address. Instruction and data memory are reached over req/ack handshake ports, so the core stalls on slow or shared memory instead of assuming fixed latency. Instantiated once per core in the multi-core top level; each instance is identified by core_number.

---
 rtl/proc_core_pkg.sv | 40 ++++
 rtl/proc_regfile.sv | 53 +++++
 rtl/handshake_processor_core.sv | 211 +++++++++++++++++++++
 tb/tb_handshake_processor_core.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_core_pkg.sv
// ============================================================================
// Module      : proc_core_pkg
// Description : Opcodes, FSM state encoding and field widths shared by the
//               handshake processor core and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_core_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDAC  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_STAC  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_LDI   = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_MVR   = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_MVA   = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_MUL   = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_AND   = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_INC   = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 4'hB;
    localparam logic [OPCODE_W-1:0] OP_JMPZ  = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_JMPNZ = 4'hD;
    localparam logic [OPCODE_W-1:0] OP_CORE  = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_ENDOP = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/proc_regfile.sv
// ============================================================================
// Module      : proc_regfile
// Description : General register file, one write port and one combinational
//               read port; out-of-range indices read 0 and ignore writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_regfile
    import proc_core_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int COUNT = 11,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_regs [COUNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < COUNT; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    // Decoded compare keeps indices beyond COUNT reading as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = r_regs[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/handshake_processor_core.sv
// ============================================================================
// Module      : handshake_processor_core
// Description : Accumulator processor core with req/ack instruction and data
//               memory ports. Optional multiply enabled by `PROC_MUL_EN`.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module handshake_processor_core
    import proc_core_pkg::*;
#(
    parameter int                   reg_width        = 12,
    parameter int                   IR_width         = 12,
    parameter int                   reg_file_count   = 11,
    parameter logic [reg_width-1:0] current_PC_value = '0,
    parameter int                   core_number      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 ins_req,
    output logic [reg_width-1:0] ins_addr,
    input  logic                 ins_ack,
    input  logic [IR_width-1:0]  ins_data,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [reg_width-1:0] dm_addr,
    output logic [reg_width-1:0] dm_wdata,
    input  logic                 dm_ack,
    input  logic [reg_width-1:0] dm_rdata,
    output logic                 endop_signal
);

    localparam int                   c_opd_w   = IR_width - OPCODE_W;
    localparam logic [reg_width-1:0] c_one     = reg_width'(1);
    localparam logic [reg_width-1:0] c_core_id = reg_width'(core_number);

    state_t               r_state;
    state_t               w_state_next;
    logic [reg_width-1:0] r_pc;
    logic [reg_width-1:0] r_ac;
    logic                 r_z;
    logic [IR_width-1:0]  r_ir;

    logic [OPCODE_W-1:0]  w_opcode;
    logic [c_opd_w-1:0]   w_operand;
    logic [reg_width-1:0] w_operand_ext;
    logic [reg_width-1:0] w_rf_rdata;

    logic                 w_ir_we;
    logic                 w_pc_we;
    logic [reg_width-1:0] w_pc_next;
    logic                 w_ac_we;
    logic [reg_width-1:0] w_ac_next;
    logic                 w_rf_we;

    assign w_opcode  = r_ir[IR_width-1 -: OPCODE_W];
    assign w_operand = r_ir[c_opd_w-1:0];

    if (c_opd_w >= reg_width) begin : g_opd_trunc
        assign w_operand_ext = w_operand[reg_width-1:0];
    end else begin : g_opd_zext
        assign w_operand_ext = {{(reg_width - c_opd_w){1'b0}}, w_operand};
    end

    proc_regfile #(
        .WIDTH (reg_width),
        .COUNT (reg_file_count),
        .IDX_W (c_opd_w)
    ) u_regfile (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (w_rf_we),
        .wr_idx  (w_operand),
        .wr_data (r_ac),
        .rd_idx  (w_operand),
        .rd_data (w_rf_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_next    = r_pc;
        w_ac_we      = 1'b0;
        w_ac_next    = r_ac;
        w_rf_we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ins_ack) begin
                    w_ir_we      = 1'b1;
                    w_pc_we      = 1'b1;
                    w_pc_next    = r_pc + c_one;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_FETCH;
                case (w_opcode)
                    OP_LDAC, OP_STAC: w_state_next = S_MEM;
                    OP_LDI: begin
                        w_ac_we   = 1'b1;
                        w_ac_next = w_operand_ext;
                    end
                    OP_MVR: w_rf_we = 1'b1;
                    OP_MVA: begin
                        w_ac_we   = 1'b1;
                        w_ac_next = w_rf_rdata;
                    end
                    OP_ADD: begin
                        w_ac_we   = 1'b1;
                        w_ac_next = r_ac + w_rf_rdata;
                    end
                    OP_SUB: begin
                        w_ac_we   = 1'b1;
                        w_ac_next = r_ac - w_rf_rdata;
                    end
`ifdef PROC_MUL_EN
                    OP_MUL: begin
                        w_ac_we   = 1'b1;
                        w_ac_next = r_ac * w_rf_rdata;
                    end
`endif
                    OP_AND: begin
                        w_ac_we   = 1'b1;
                        w_ac_next = r_ac & w_rf_rdata;
                    end
                    OP_INC: begin
                        w_ac_we   = 1'b1;
                        w_ac_next = r_ac + c_one;
                    end
                    OP_JMP: begin
                        w_pc_we   = 1'b1;
                        w_pc_next = w_operand_ext;
                    end
                    OP_JMPZ: begin
                        w_pc_we   = r_z;
                        w_pc_next = w_operand_ext;
                    end
                    OP_JMPNZ: begin
                        w_pc_we   = ~r_z;
                        w_pc_next = w_operand_ext;
                    end
                    OP_CORE: begin
                        w_ac_we   = 1'b1;
                        w_ac_next = c_core_id;
                    end
                    OP_ENDOP: w_state_next = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dm_ack) begin
                    w_state_next = S_FETCH;
                    if (w_opcode == OP_LDAC) begin
                        w_ac_we   = 1'b1;
                        w_ac_next = dm_rdata;
                    end
                end
            end
            S_HALT: ;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= current_PC_value;
            r_ac <= '0;
            r_z  <= 1'b1;
            r_ir <= '0;
        end else begin
            if (w_ir_we) begin
                r_ir <= ins_data;
            end
            if (w_pc_we) begin
                r_pc <= w_pc_next;
            end
            if (w_ac_we) begin
                r_ac <= w_ac_next;
                r_z  <= (w_ac_next == '0);
            end
        end
    end

    // Requests and their payloads are pure functions of state, so they stay
    // stable for the whole stall and vanish immediately on reset.
    assign ins_req      = (r_state == S_FETCH);
    assign ins_addr     = r_pc;
    assign dm_req       = (r_state == S_MEM);
    assign dm_we        = dm_req && (w_opcode == OP_STAC);
    assign dm_addr      = dm_req ? w_operand_ext : '0;
    assign dm_wdata     = dm_req ? r_ac : '0;
    assign endop_signal = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_handshake_processor_core.sv
// ============================================================================
// Module      : tb_handshake_processor_core
// Description : Directed self-checking bench with handshake memory responders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_handshake_processor_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUT A: default 12-bit configuration ----------------
    logic        reset_a = 1'b1;
    logic        start_a = 1'b0;
    logic        ins_req_a;
    logic [11:0] ins_addr_a;
    logic        ins_ack_a = 1'b0;
    logic [11:0] ins_data_a = '0;
    logic        dm_req_a;
    logic        dm_we_a;
    logic [11:0] dm_addr_a;
    logic [11:0] dm_wdata_a;
    logic        dm_ack_a = 1'b0;
    logic [11:0] dm_rdata_a = '0;
    logic        endop_a;

    handshake_processor_core #(
        .reg_width        (12),
        .IR_width         (12),
        .reg_file_count   (11),
        .current_PC_value (12'h000),
        .core_number      (0)
    ) dut_a (
        .clk          (clk),
        .reset        (reset_a),
        .start        (start_a),
        .ins_req      (ins_req_a),
        .ins_addr     (ins_addr_a),
        .ins_ack      (ins_ack_a),
        .ins_data     (ins_data_a),
        .dm_req       (dm_req_a),
        .dm_we        (dm_we_a),
        .dm_addr      (dm_addr_a),
        .dm_wdata     (dm_wdata_a),
        .dm_ack       (dm_ack_a),
        .dm_rdata     (dm_rdata_a),
        .endop_signal (endop_a)
    );

    // ---------------- DUT B: 16-bit, PC 0x100, core 3 ----------------
    logic        reset_b = 1'b1;
    logic        start_b = 1'b0;
    logic        ins_req_b;
    logic [15:0] ins_addr_b;
    logic        ins_ack_b = 1'b0;
    logic [11:0] ins_data_b = '0;
    logic        dm_req_b;
    logic        dm_we_b;
    logic [15:0] dm_addr_b;
    logic [15:0] dm_wdata_b;
    logic        dm_ack_b = 1'b0;
    logic [15:0] dm_rdata_b = '0;
    logic        endop_b;

    handshake_processor_core #(
        .reg_width        (16),
        .IR_width         (12),
        .reg_file_count   (11),
        .current_PC_value (16'h0100),
        .core_number      (3)
    ) dut_b (
        .clk          (clk),
        .reset        (reset_b),
        .start        (start_b),
        .ins_req      (ins_req_b),
        .ins_addr     (ins_addr_b),
        .ins_ack      (ins_ack_b),
        .ins_data     (ins_data_b),
        .dm_req       (dm_req_b),
        .dm_we        (dm_we_b),
        .dm_addr      (dm_addr_b),
        .dm_wdata     (dm_wdata_b),
        .dm_ack       (dm_ack_b),
        .dm_rdata     (dm_rdata_b),
        .endop_signal (endop_b)
    );

    // ---------------- memory model A ----------------
    logic [11:0] imem_a [4096];
    logic [11:0] dmem_a [256];
    bit          wr_flag_a [256];
    int          wr_cnt_a   = 0;
    int          stab_err_a = 0;
    bit          rand_mode  = 1'b0;
    bit          dm_hold    = 1'b0;

    int          i_cnt = 0, i_dly = 0;
    logic [11:0] i_addr_q = '0;
    int          d_cnt = 0, d_dly = 0;
    logic [11:0] d_addr_q = '0, d_wdata_q = '0;
    logic        d_we_q = 1'b0;

    always @(negedge clk) begin
        if (reset_a) begin
            ins_ack_a = 1'b0;
            dm_ack_a  = 1'b0;
            i_cnt     = 0;
            d_cnt     = 0;
        end else begin
            if (!ins_req_a || ins_ack_a) begin
                ins_ack_a = 1'b0;
                i_cnt     = 0;
            end else begin
                if (i_cnt == 0) begin
                    i_dly    = rand_mode ? int'($urandom_range(0, 5)) : 0;
                    i_addr_q = ins_addr_a;
                end else if (ins_addr_a !== i_addr_q) begin
                    stab_err_a++;
                end
                if (i_cnt >= i_dly) begin
                    ins_ack_a  = 1'b1;
                    ins_data_a = imem_a[ins_addr_a];
                end
                i_cnt++;
            end

            if (!dm_req_a || dm_ack_a) begin
                dm_ack_a = 1'b0;
                d_cnt    = 0;
            end else begin
                if (d_cnt == 0) begin
                    d_dly     = rand_mode ? int'($urandom_range(0, 5)) : 0;
                    d_addr_q  = dm_addr_a;
                    d_wdata_q = dm_wdata_a;
                    d_we_q    = dm_we_a;
                end else if (dm_addr_a !== d_addr_q || dm_wdata_a !== d_wdata_q ||
                             dm_we_a !== d_we_q) begin
                    stab_err_a++;
                end
                if (d_cnt >= d_dly && !dm_hold) begin
                    dm_ack_a = 1'b1;
                    if (dm_we_a) begin
                        dmem_a[dm_addr_a[7:0]]    = dm_wdata_a;
                        wr_flag_a[dm_addr_a[7:0]] = 1'b1;
                        wr_cnt_a++;
                    end else begin
                        dm_rdata_a = dmem_a[dm_addr_a[7:0]];
                    end
                end
                d_cnt++;
            end
        end
    end

    // ---------------- memory model B (zero wait) ----------------
    logic [11:0] imem_b [512];
    bit          first_seen_b = 1'b0;
    logic [15:0] first_addr_b = '0;
    logic [15:0] wr_addr_b    = '0;
    logic [15:0] wr_data_b    = '0;
    int          wr_cnt_b     = 0;

    always @(negedge clk) begin
        if (reset_b) begin
            ins_ack_b = 1'b0;
            dm_ack_b  = 1'b0;
        end else begin
            ins_ack_b = ins_req_b && !ins_ack_b;
            if (ins_ack_b) begin
                ins_data_b = imem_b[ins_addr_b[8:0]];
                if (!first_seen_b) begin
                    first_seen_b = 1'b1;
                    first_addr_b = ins_addr_b;
                end
            end
            dm_ack_b = dm_req_b && !dm_ack_b;
            if (dm_ack_b && dm_we_b) begin
                wr_addr_b = dm_addr_b;
                wr_data_b = dm_wdata_b;
                wr_cnt_b++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic reset_a_task();
        @(negedge clk);
        reset_a   = 1'b1;
        start_a   = 1'b0;
        rand_mode = 1'b0;
        dm_hold   = 1'b0;
        for (int i = 0; i < 4096; i++) imem_a[i] = 12'hF00;
        for (int i = 0; i < 256; i++) begin
            dmem_a[i]    = '0;
            wr_flag_a[i] = 1'b0;
        end
        wr_cnt_a   = 0;
        stab_err_a = 0;
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b0;
    endtask

    task automatic run_a(input int budget, output int cycles);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        cycles  = 0;
        while (!endop_a && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_value("halt_reached", 32'(endop_a), 32'd1);
    endtask

    task automatic load_t1();
        imem_a[0] = 12'h305;  // LDI 5
        imem_a[1] = 12'h402;  // MVR 2
        imem_a[2] = 12'h303;  // LDI 3
        imem_a[3] = 12'h602;  // ADD 2
        imem_a[4] = 12'h240;  // STAC 0x40
        imem_a[5] = 12'hF00;  // ENDOP
    endtask

    int cyc;
    int quiet;
    int k;

    initial begin
        // ---- reset state ----
        #12;
        check_value("rst_ins_req",  32'(ins_req_a),  32'd0);
        check_value("rst_ins_addr", 32'(ins_addr_a), 32'h000);
        check_value("rst_dm_req",   32'(dm_req_a),   32'd0);
        check_value("rst_dm_we",    32'(dm_we_a),    32'd0);
        check_value("rst_dm_addr",  32'(dm_addr_a),  32'd0);
        check_value("rst_dm_wdata", 32'(dm_wdata_a), 32'd0);
        check_value("rst_endop",    32'(endop_a),    32'd0);
        check_value("rst_b_addr",   32'(ins_addr_b), 32'h0100);

        // ---- test 1: zero-wait program ----
        reset_a_task();
        load_t1();
        run_a(200, cyc);
        check_value("t1_cycles",   32'(cyc),           32'd13);
        check_value("t1_wr_cnt",   32'(wr_cnt_a),      32'd1);
        check_value("t1_wr_flag",  32'(wr_flag_a[64]), 32'd1);
        check_value("t1_wr_data",  32'(dmem_a[64]),    32'd8);
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            start_a = (i == 2);
            @(posedge clk);
            #1;
            if (ins_req_a || dm_req_a || !endop_a) quiet++;
        end
        start_a = 1'b0;
        check_value("t1_quiet_after_halt", 32'(quiet), 32'd0);

        // ---- test 2: random handshake delays ----
        reset_a_task();
        load_t1();
        rand_mode = 1'b1;
        run_a(500, cyc);
        check_value("t2_wr_cnt",    32'(wr_cnt_a),   32'd1);
        check_value("t2_wr_data",   32'(dmem_a[64]), 32'd8);
        check_value("t2_stability", 32'(stab_err_a), 32'd0);

        // ---- test 3: SUB, wrap, conditional jumps ----
        reset_a_task();
        imem_a[12'h00] = 12'h301;  // LDI 1
        imem_a[12'h01] = 12'h700;  // SUB 0
        imem_a[12'h02] = 12'h241;  // STAC 0x41 -> 1
        imem_a[12'h03] = 12'h300;  // LDI 0
        imem_a[12'h04] = 12'hC20;  // JMPZ 0x20 (taken)
        imem_a[12'h05] = 12'h3EE;
        imem_a[12'h06] = 12'h250;  // must not execute
        imem_a[12'h20] = 12'hD30;  // JMPNZ 0x30 (not taken)
        imem_a[12'h21] = 12'h301;  // LDI 1
        imem_a[12'h22] = 12'h401;  // MVR 1
        imem_a[12'h23] = 12'h300;  // LDI 0
        imem_a[12'h24] = 12'h701;  // SUB 1 -> 0xFFF
        imem_a[12'h25] = 12'h242;  // STAC 0x42
        imem_a[12'h26] = 12'hD30;  // JMPNZ 0x30 (taken)
        imem_a[12'h27] = 12'h3DD;
        imem_a[12'h28] = 12'h251;  // must not execute
        imem_a[12'h30] = 12'hA00;  // INC -> 0x000
        imem_a[12'h31] = 12'h243;  // STAC 0x43
        imem_a[12'h32] = 12'hC38;  // JMPZ 0x38 (taken)
        imem_a[12'h33] = 12'h3DC;
        imem_a[12'h34] = 12'h252;  // must not execute
        run_a(300, cyc);
        check_value("t3_sub_r0",    32'(dmem_a[8'h41]),    32'h001);
        check_value("t3_sub_wrap",  32'(dmem_a[8'h42]),    32'hFFF);
        check_value("t3_inc_wrap",  32'(dmem_a[8'h43]),    32'h000);
        check_value("t3_inc_wr",    32'(wr_flag_a[8'h43]), 32'd1);
        check_value("t3_jmpz_skip", 32'(wr_flag_a[8'h50]), 32'd0);
        check_value("t3_jmpnz_tkn", 32'(wr_flag_a[8'h51]), 32'd0);
        check_value("t3_z_from_inc",32'(wr_flag_a[8'h52]), 32'd0);
        check_value("t3_wr_cnt",    32'(wr_cnt_a),         32'd3);

        // ---- test 4: DUT B, CORE and start address ----
        for (int i = 0; i < 512; i++) imem_b[i] = 12'hF00;
        imem_b[9'h100] = 12'hE00;  // CORE
        imem_b[9'h101] = 12'h210;  // STAC 0x10
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        k = 0;
        while (!endop_b && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_value("t4_halt",       32'(endop_b),      32'd1);
        check_value("t4_cycles",     32'(k),            32'd7);
        check_value("t4_first_addr", 32'(first_addr_b), 32'h0100);
        check_value("t4_wr_cnt",     32'(wr_cnt_b),     32'd1);
        check_value("t4_wr_addr",    32'(wr_addr_b),    32'h0010);
        check_value("t4_wr_data",    32'(wr_data_b),    32'h0003);

        // ---- test 5: reset while a data request is outstanding ----
        reset_a_task();
        imem_a[0] = 12'h301;  // LDI 1
        imem_a[1] = 12'h240;  // STAC 0x40
        dm_hold   = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        k = 0;
        while (!dm_req_a && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_value("t5_in_mem", 32'(dm_req_a), 32'd1);
        @(posedge clk);
        #3;
        reset_a = 1'b1;
        #1;
        check_value("t5_dm_req_drop", 32'(dm_req_a),   32'd0);
        check_value("t5_pc_reset",    32'(ins_addr_a), 32'h000);
        @(negedge clk);
        reset_a = 1'b0;
        dm_hold = 1'b0;
        quiet   = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (ins_req_a || dm_req_a) quiet++;
        end
        check_value("t5_stays_idle", 32'(quiet),    32'd0);
        check_value("t5_no_write",   32'(wr_cnt_a), 32'd0);
        run_a(100, cyc);
        check_value("t5_rerun_data", 32'(dmem_a[8'h40]), 32'h001);

        // ---- test 6: MUL, AND, LDAC, out-of-range register ----
        reset_a_task();
        dmem_a[8'h60]  = 12'hABC;
        imem_a[12'h00] = 12'h307;  // LDI 7
        imem_a[12'h01] = 12'h401;  // MVR 1
        imem_a[12'h02] = 12'h306;  // LDI 6
        imem_a[12'h03] = 12'h801;  // MUL 1
        imem_a[12'h04] = 12'h244;  // STAC 0x44
        imem_a[12'h05] = 12'h33C;  // LDI 0x3C
        imem_a[12'h06] = 12'h403;  // MVR 3
        imem_a[12'h07] = 12'h3F5;  // LDI 0xF5
        imem_a[12'h08] = 12'h903;  // AND 3 -> 0x34
        imem_a[12'h09] = 12'h246;  // STAC 0x46
        imem_a[12'h0A] = 12'h160;  // LDAC 0x60
        imem_a[12'h0B] = 12'h247;  // STAC 0x47
        imem_a[12'h0C] = 12'h309;  // LDI 9
        imem_a[12'h0D] = 12'h40F;  // MVR 15 (ignored)
        imem_a[12'h0E] = 12'h50F;  // MVA 15 -> 0, Z=1
        imem_a[12'h0F] = 12'hC18;  // JMPZ 0x18
        imem_a[12'h10] = 12'h3DB;
        imem_a[12'h11] = 12'h253;  // must not execute
        imem_a[12'h18] = 12'h245;  // STAC 0x45
        run_a(300, cyc);
`ifdef PROC_MUL_EN
        check_value("t6_mul", 32'(dmem_a[8'h44]), 32'd42);
`else
        check_value("t6_mul", 32'(dmem_a[8'h44]), 32'd6);
`endif
        check_value("t6_and",      32'(dmem_a[8'h46]),    32'h034);
        check_value("t6_ldac",     32'(dmem_a[8'h47]),    32'hABC);
        check_value("t6_mva_oor",  32'(dmem_a[8'h45]),    32'h000);
        check_value("t6_mva_wr",   32'(wr_flag_a[8'h45]), 32'd1);
        check_value("t6_mva_z",    32'(wr_flag_a[8'h53]), 32'd0);
        check_value("t6_stab",     32'(stab_err_a),       32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
